// File: rtl/sumador_acumulador_if.sv
// Bundle between the pipelined adder, the accumulator stage and its consumer.
// Carries the sample stream (no backpressure) and the valid/ready result port.
// master = the side that drives samples and acc_ready; slave = the accumulator.
interface sumador_acumulador_if #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] sum30_dd;
    logic [DATA_W-1:0] idx_dd;
    logic              flush;
    logic              acc_ready;
    logic              acc_valid;
    logic [ACC_W-1:0]  acc_data_out;
    logic [DATA_W-1:0] acc_idx_out;
    logic [3:0]        acc_cnt_out;
    logic              err_overrun;
    logic              acc_sat;

    modport master (
        output in_valid, sum30_dd, idx_dd, flush, acc_ready,
        input  acc_valid, acc_data_out, acc_idx_out, acc_cnt_out, err_overrun, acc_sat
    );

    modport slave (
        input  in_valid, sum30_dd, idx_dd, flush, acc_ready,
        output acc_valid, acc_data_out, acc_idx_out, acc_cnt_out, err_overrun, acc_sat
    );
endinterface

// File: rtl/sumador_acumulador.sv
// Accumulates WINDOW adder sums (or fewer on flush) into one registered total; SUM_ACC_SAT_EN selects clamping.
// Latency: result visible one edge after the closing sample.
// Input never stalls; a result closing while the output is held and not ready is dropped, err_overrun sticks.
module sumador_acumulador #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    sumador_acumulador_if.slave  bus
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ACC_W-1:0]  acc;
    logic              acc_clamped;
    logic [DATA_W-1:0] last_idx;

    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic [DATA_W-1:0] res_idx;
    logic [3:0]        res_cnt;
    logic              res_sat;
    logic              overrun;

    logic [ACC_W-1:0]  sum_next;
    logic              clamp_next;
    logic [4:0]        cnt_inc;
    logic              close;
    logic              slot_free;
    logic [ACC_W-1:0]  tot_data;
    logic [3:0]        tot_cnt;
    logic [DATA_W-1:0] tot_idx;
    logic              tot_sat;

`ifdef SUM_ACC_SAT_EN
    logic [ACC_W:0]    sum_wide;

    // Saturating add: once the window has clamped it stays at the ceiling.
    always_comb begin
        sum_wide   = {1'b0, acc} + {1'b0, ACC_W'(bus.sum30_dd)};
        clamp_next = acc_clamped | sum_wide[ACC_W];
        sum_next   = clamp_next ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end
`else
    // Plain modulo add; the clamp flag never sets in this build.
    always_comb begin
        sum_next   = acc + ACC_W'(bus.sum30_dd);
        clamp_next = 1'b0;
    end
`endif

    // Window-close decision and the result that would be loaded on this edge.
    always_comb begin
        cnt_inc   = {1'b0, cnt} + 5'd1;
        close     = bus.in_valid ? ((cnt_inc == 5'(WINDOW)) || bus.flush)
                                 : (bus.flush && (state == ACC));
        slot_free = !res_valid || bus.acc_ready;
        tot_data  = bus.in_valid ? sum_next      : acc;
        tot_cnt   = bus.in_valid ? cnt_inc[3:0]  : cnt;
        tot_idx   = bus.in_valid ? bus.idx_dd    : last_idx;
        tot_sat   = bus.in_valid ? clamp_next    : acc_clamped;
    end

    // Window FSM plus the registered result slot and its handshake.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            acc_clamped <= 1'b0;
            last_idx    <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_idx     <= '0;
            res_cnt     <= '0;
            res_sat     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (close) begin
                state       <= IDLE;
                cnt         <= '0;
                acc         <= '0;
                acc_clamped <= 1'b0;
            end else if (bus.in_valid) begin
                state       <= ACC;
                cnt         <= cnt_inc[3:0];
                acc         <= sum_next;
                acc_clamped <= clamp_next;
            end

            if (bus.in_valid) begin
                last_idx <= bus.idx_dd;
            end

            // A consume on the same edge frees the slot for the new result.
            if (close && slot_free) begin
                res_valid <= 1'b1;
                res_data  <= tot_data;
                res_idx   <= tot_idx;
                res_cnt   <= tot_cnt;
                res_sat   <= tot_sat;
            end else begin
                if (close) begin
                    overrun <= 1'b1;
                end
                if (res_valid && bus.acc_ready) begin
                    res_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.acc_valid    = res_valid;
    assign bus.acc_data_out = res_data;
    assign bus.acc_idx_out  = res_idx;
    assign bus.acc_cnt_out  = res_cnt;
    assign bus.err_overrun  = overrun;
    assign bus.acc_sat      = res_sat;

endmodule

// File: tb/tb_sumador_acumulador.sv
// Bench for sumador_acumulador: two instances (ACC_W=8 and ACC_W=5) share one sample stream.
// A queue-based window model predicts every output; it is compared on each falling edge.
// Directed steps also pin literal values on both the DUT and the model.
module tb_sumador_acumulador;

    localparam int WINDOW = 4;
`ifdef SUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int W8 = 8;
    localparam int W5 = 5;

    logic clk;
    logic reset_L;
    bit   cmp_en;
    int   checks;
    int   errors;

    sumador_acumulador_if #(.DATA_W(4), .ACC_W(W8)) b8 ();
    sumador_acumulador_if #(.DATA_W(4), .ACC_W(W5)) b5 ();

    assign b5.in_valid  = b8.in_valid;
    assign b5.sum30_dd  = b8.sum30_dd;
    assign b5.idx_dd    = b8.idx_dd;
    assign b5.flush     = b8.flush;
    assign b5.acc_ready = b8.acc_ready;

    sumador_acumulador #(.DATA_W(4), .ACC_W(W8), .WINDOW(WINDOW)) dut (
        .clk(clk), .reset_L(reset_L), .bus(b8));
    sumador_acumulador #(.DATA_W(4), .ACC_W(W5), .WINDOW(WINDOW)) dut5 (
        .clk(clk), .reset_L(reset_L), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: open window as a list of samples, plus expected outputs.
    int q[$];
    int m_last;
    bit ev;
    int ei;
    int ec;
    bit eo;
    int ed[2];
    bit es[2];

    function automatic void wsum(input int w, output int tot, output bit sat);
        int mx;
        mx  = (1 << w) - 1;
        tot = 0;
        sat = 1'b0;
        foreach (q[j]) begin
            tot = tot + q[j];
            if (SAT && tot > mx) begin
                tot = mx;
                sat = 1'b1;
            end
        end
        tot = tot % (1 << w);
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q.delete();
            m_last = 0;
            ev = 1'b0; ei = 0; ec = 0; eo = 1'b0;
            ed[0] = 0; ed[1] = 0; es[0] = 1'b0; es[1] = 1'b0;
        end else begin : mdl
            bit cl;
            bit fr;
            if (b8.in_valid) begin
                q.push_back(int'(b8.sum30_dd));
                m_last = int'(b8.idx_dd);
            end
            cl = (b8.in_valid && q.size() == WINDOW) || (b8.flush && q.size() > 0);
            fr = !ev || b8.acc_ready;
            if (cl && fr) begin
                ev = 1'b1;
                ei = m_last;
                ec = q.size();
                wsum(W8, ed[0], es[0]);
                wsum(W5, ed[1], es[1]);
            end else begin
                if (cl) eo = 1'b1;
                if (ev && b8.acc_ready) ev = 1'b0;
            end
            if (cl) q.delete();
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid8",  32'(b8.acc_valid),    32'(ev));
            chk("data8",   32'(b8.acc_data_out), 32'(ed[0]));
            chk("idx8",    32'(b8.acc_idx_out),  32'(ei));
            chk("cnt8",    32'(b8.acc_cnt_out),  32'(ec));
            chk("ovr8",    32'(b8.err_overrun),  32'(eo));
            chk("sat8",    32'(b8.acc_sat),      32'(es[0]));
            chk("valid5",  32'(b5.acc_valid),    32'(ev));
            chk("data5",   32'(b5.acc_data_out), 32'(ed[1]));
            chk("ovr5",    32'(b5.err_overrun),  32'(eo));
            chk("sat5",    32'(b5.acc_sat),      32'(es[1]));
        end
    end

    task automatic step(input bit v, input int s, input int i, input bit f, input bit r);
        b8.in_valid  = v;
        b8.sum30_dd  = 4'(s);
        b8.idx_dd    = 4'(i);
        b8.flush     = f;
        b8.acc_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string n);
        chk({n, "_valid"}, 32'(b8.acc_valid),    0);
        chk({n, "_data"},  32'(b8.acc_data_out), 0);
        chk({n, "_idx"},   32'(b8.acc_idx_out),  0);
        chk({n, "_cnt"},   32'(b8.acc_cnt_out),  0);
        chk({n, "_ovr"},   32'(b8.err_overrun),  0);
        chk({n, "_sat"},   32'(b8.acc_sat),      0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        reset_L = 1'b1;
        b8.in_valid = 1'b0; b8.sum30_dd = '0; b8.idx_dd = '0;
        b8.flush = 1'b0; b8.acc_ready = 1'b0;
        #2 reset_L = 1'b0;
        cmp_en = 1'b1;
        #1 all_zero("rst0");
        @(posedge clk); #1;
        reset_L = 1'b1;

        // T2: full window with ready held high
        step(1, 3, 1, 0, 1);
        step(1, 4, 2, 0, 1);
        step(1, 5, 3, 0, 1);
        chk("t2_early_valid", 32'(b8.acc_valid), 0);
        step(1, 6, 4, 0, 1);
        chk("t2_valid", 32'(b8.acc_valid),    1);
        chk("t2_data",  32'(b8.acc_data_out), 18);
        chk("t2_idx",   32'(b8.acc_idx_out),  4);
        chk("t2_cnt",   32'(b8.acc_cnt_out),  4);
        chk("t2_model", 32'(ed[0]),           18);
        step(0, 0, 0, 0, 1);
        chk("t2_drop",  32'(b8.acc_valid),    0);
        chk("t2_hold",  32'(b8.acc_data_out), 18);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);

        // T1: reset two samples into a window
        step(1, 5, 1, 0, 1);
        step(1, 6, 2, 0, 1);
        reset_L = 1'b0;
        #1 all_zero("t1_rst");
        #1 reset_L = 1'b1;
        step(1, 1, 1, 0, 1);
        step(1, 1, 2, 0, 1);
        step(1, 1, 3, 0, 1);
        step(1, 1, 4, 0, 1);
        chk("t1_data", 32'(b8.acc_data_out), 4);
        chk("t1_cnt",  32'(b8.acc_cnt_out),  4);

        // T3: bubbles, flush without a sample, idle flush, one-sample flush
        step(1, 7, 5, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 8, 6, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("t3_valid", 32'(b8.acc_valid),    1);
        chk("t3_data",  32'(b8.acc_data_out), 15);
        chk("t3_cnt",   32'(b8.acc_cnt_out),  2);
        chk("t3_idx",   32'(b8.acc_idx_out),  6);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("t3_idle_flush", 32'(b8.acc_valid), 0);
        step(1, 9, 7, 1, 1);
        chk("t3_one_data", 32'(b8.acc_data_out), 9);
        chk("t3_one_cnt",  32'(b8.acc_cnt_out),  1);

        // T6: wide sums, 8-bit holds 60, 5-bit wraps or clamps
        step(1, 15, 8,  0, 1);
        step(1, 15, 9,  0, 1);
        step(1, 15, 10, 0, 1);
        step(1, 15, 11, 0, 1);
        chk("t6_data8", 32'(b8.acc_data_out), 60);
        chk("t6_sat8",  32'(b8.acc_sat),      0);
        chk("t6_data5", 32'(b5.acc_data_out), SAT ? 31 : 28);
        chk("t6_sat5",  32'(b5.acc_sat),      SAT ? 1 : 0);
        chk("t6_model5", 32'(ed[1]),          SAT ? 31 : 28);
        step(0, 0, 0, 0, 1);

        // T4: backpressure and overrun
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 3, 0, 0);
        step(1, 1, 4, 0, 0);
        step(1, 2, 5, 0, 0);
        step(1, 2, 6, 0, 0);
        step(1, 2, 7, 0, 0);
        step(1, 2, 8, 0, 0);
        chk("t4_valid", 32'(b8.acc_valid),    1);
        chk("t4_data",  32'(b8.acc_data_out), 4);
        chk("t4_idx",   32'(b8.acc_idx_out),  4);
        chk("t4_ovr",   32'(b8.err_overrun),  1);
        step(0, 0, 0, 0, 1);
        chk("t4_consumed", 32'(b8.acc_valid),    0);
        step(0, 0, 0, 0, 1);
        chk("t4_no8",      32'(b8.acc_valid),    0);
        chk("t4_hold",     32'(b8.acc_data_out), 4);
        chk("t4_sticky",   32'(b8.err_overrun),  1);

        // T5: consume and close on the same edge
        reset_L = 1'b0;
        #1 reset_L = 1'b1;
        step(1, 1, 1, 0, 0);
        step(1, 2, 2, 0, 0);
        step(1, 3, 3, 0, 0);
        step(1, 4, 4, 0, 0);
        chk("t5_first", 32'(b8.acc_data_out), 10);
        step(1, 5, 5, 0, 0);
        step(1, 5, 6, 0, 0);
        step(1, 5, 7, 0, 0);
        step(1, 5, 8, 0, 1);
        chk("t5_valid", 32'(b8.acc_valid),    1);
        chk("t5_data",  32'(b8.acc_data_out), 20);
        chk("t5_idx",   32'(b8.acc_idx_out),  8);
        chk("t5_ovr",   32'(b8.err_overrun),  0);
        step(0, 0, 0, 0, 1);
        chk("t5_drop",  32'(b8.acc_valid),    0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
